// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive line decoder and unstuffer.
package usb_rx_pkg;

    // Line state encoded as {dp, dm} so the sampled pins cast straight to the enum
    typedef enum logic [1:0] {
        SE0 = 2'b00,
        K   = 2'b01,
        J   = 2'b10,
        SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP,
        ERROR
    } rx_state_t;

    // SYNC decoded bits, bit 0 first in time: seven zeros then a one
    localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
    // Consecutive ones after which the transmitter inserts a stuffed zero
    localparam logic [2:0] MAX_ONES     = 3'd6;
    // Consecutive J symbols that release the receiver from ERROR
    localparam logic [2:0] IDLE_J_COUNT = 3'd7;

    function automatic logic is_jk(input line_state_t ls);
        return (ls == J) || (ls == K);
    endfunction

endpackage

// File: rtl/rx_nrzi_unstuff_if.sv
// Bus between the line sampler and the receive block: sampled line in, decoded bits and status out.
interface rx_nrzi_unstuff_if;
    logic in_valid;
    logic dp;
    logic dm;
    logic out_bit;
    logic out_valid;
    logic pkt_active;
    logic pkt_done;
    logic stuff_err;
    logic eop_err;

    // Side that drives line samples and consumes decoded data
    modport master (
        output in_valid, dp, dm,
        input  out_bit, out_valid, pkt_active, pkt_done, stuff_err, eop_err
    );

    // Receive block side
    modport slave (
        input  in_valid, dp, dm,
        output out_bit, out_valid, pkt_active, pkt_done, stuff_err, eop_err
    );
endinterface

// File: rtl/nrzi_line_decode.sv
// Maps dp/dm to a line state and NRZI-decodes J/K symbols against the previous J/K symbol.
module nrzi_line_decode
    import usb_rx_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid_i,
    input  logic        dp_i,
    input  logic        dm_i,
    input  logic        prev_to_j_i,
    output line_state_t line_o,
    output logic        bit_o
);

    line_state_t prev_q;
    line_state_t prev_d;

    assign line_o = line_state_t'({dp_i, dm_i});
    // Unchanged symbol decodes as 1, a transition as 0; only meaningful for J/K
    assign bit_o  = (line_o == prev_q);

    // Previous symbol follows accepted J/K symbols; forced back to J when a packet ends
    always_comb begin
        prev_d = prev_q;
        if (in_valid_i) begin
            if (prev_to_j_i) begin
                prev_d = J;
            end else if (is_jk(line_o)) begin
                prev_d = line_o;
            end
        end
    end

    // Previous-symbol register, idles at J
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= J;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/rx_nrzi_unstuff.sv
// Receive FSM: SYNC detection, bit unstuffing, EOP checking and error recovery.
module rx_nrzi_unstuff
    import usb_rx_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    rx_nrzi_unstuff_if.slave   bus
);

    line_state_t line;
    logic        dec_bit;
    logic        prev_to_j;

    rx_state_t   state_q;
    logic [2:0]  ones_cnt_q;
    logic [2:0]  sync_cnt_q;
    logic [2:0]  idle_cnt_q;
    logic [1:0]  se0_cnt_q;

    logic        out_bit_q;
    logic        out_valid_q;
    logic        pkt_active_q;
    logic        pkt_done_q;
    logic        stuff_err_q;
    logic        eop_err_q;

    // A clean EOP terminates on J; the decoder re-arms its previous symbol there
    assign prev_to_j = bus.in_valid && (state_q == EOP) && (line == J) && (se0_cnt_q != 2'd0);

    nrzi_line_decode u_line (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid_i  (bus.in_valid),
        .dp_i        (bus.dp),
        .dm_i        (bus.dm),
        .prev_to_j_i (prev_to_j),
        .line_o      (line),
        .bit_o       (dec_bit)
    );

    // Packet FSM with counters and registered outputs; pulses last one accepted symbol
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ones_cnt_q   <= 3'd0;
            sync_cnt_q   <= 3'd0;
            idle_cnt_q   <= 3'd0;
            se0_cnt_q    <= 2'd0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            pkt_active_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            stuff_err_q  <= 1'b0;
            eop_err_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            stuff_err_q <= 1'b0;
            eop_err_q   <= 1'b0;
            if (bus.in_valid) begin
                case (state_q)
                    IDLE: begin
                        if (line == K) begin
                            state_q    <= SYNC;
                            sync_cnt_q <= 3'd1;
                        end
                    end
                    SYNC: begin
                        if (line == SE1) begin
                            state_q    <= ERROR;
                            eop_err_q  <= 1'b1;
                            sync_cnt_q <= 3'd0;
                            idle_cnt_q <= 3'd0;
                            se0_cnt_q  <= 2'd0;
                        end else if (line == SE0 || dec_bit != SYNC_PATTERN[sync_cnt_q]) begin
                            state_q    <= IDLE;
                            sync_cnt_q <= 3'd0;
                        end else if (sync_cnt_q == 3'd7) begin
                            state_q      <= DATA;
                            sync_cnt_q   <= 3'd0;
                            ones_cnt_q   <= 3'd1;
                            pkt_active_q <= 1'b1;
                        end else begin
                            sync_cnt_q <= sync_cnt_q + 3'd1;
                        end
                    end
                    DATA: begin
                        case (line)
                            SE0: begin
                                state_q    <= EOP;
                                se0_cnt_q  <= 2'd1;
                                ones_cnt_q <= 3'd0;
                            end
                            SE1: begin
                                state_q      <= ERROR;
                                eop_err_q    <= 1'b1;
                                pkt_active_q <= 1'b0;
                                ones_cnt_q   <= 3'd0;
                                idle_cnt_q   <= 3'd0;
                                se0_cnt_q    <= 2'd0;
                            end
                            default: begin
                                if (ones_cnt_q == MAX_ONES) begin
                                    // Position of a stuffed zero: drop it, or flag a seventh one
                                    ones_cnt_q <= 3'd0;
                                    if (dec_bit) begin
                                        state_q      <= ERROR;
                                        stuff_err_q  <= 1'b1;
                                        pkt_active_q <= 1'b0;
                                        idle_cnt_q   <= 3'd0;
                                        se0_cnt_q    <= 2'd0;
                                    end
                                end else begin
                                    out_bit_q   <= dec_bit;
                                    out_valid_q <= 1'b1;
                                    ones_cnt_q  <= dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                                end
                            end
                        endcase
                    end
                    EOP: begin
                        if (line == J) begin
                            state_q      <= IDLE;
                            pkt_done_q   <= 1'b1;
                            pkt_active_q <= 1'b0;
                            se0_cnt_q    <= 2'd0;
                        end else if (line == SE0 && se0_cnt_q == 2'd1) begin
                            se0_cnt_q <= 2'd2;
                        end else begin
                            state_q      <= ERROR;
                            eop_err_q    <= 1'b1;
                            pkt_active_q <= 1'b0;
                            se0_cnt_q    <= 2'd0;
                            idle_cnt_q   <= 3'd0;
                        end
                    end
                    ERROR: begin
                        case (line)
                            J: begin
                                if (se0_cnt_q != 2'd0 || idle_cnt_q == IDLE_J_COUNT - 3'd1) begin
                                    state_q    <= IDLE;
                                    idle_cnt_q <= 3'd0;
                                    se0_cnt_q  <= 2'd0;
                                end else begin
                                    idle_cnt_q <= idle_cnt_q + 3'd1;
                                end
                            end
                            SE0: begin
                                se0_cnt_q  <= 2'd1;
                                idle_cnt_q <= 3'd0;
                            end
                            default: begin
                                se0_cnt_q  <= 2'd0;
                                idle_cnt_q <= 3'd0;
                            end
                        endcase
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out_bit    = out_bit_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.pkt_active = pkt_active_q;
    assign bus.pkt_done   = pkt_done_q;
    assign bus.stuff_err  = stuff_err_q;
    assign bus.eop_err    = eop_err_q;

endmodule

// File: doc/rx_nrzi_unstuff.md
RX_NRZI_UNSTUFF -- requirements
Module: rx_nrzi_unstuff

Interface
REQ-001 SHALL have port clock, input, 1, rising-edge system clock.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, one sampled line symbol per cycle where high.
REQ-004 SHALL have ports dp and dm, input, 1 each, sampled bus lines: J=10, K=01, SE0=00, SE1=11.
REQ-005 SHALL have port out_bit, output, 1, decoded and unstuffed data bit.
REQ-006 SHALL have port out_valid, output, 1, out_bit is valid this cycle; this is the per-bit enable for the downstream CRC16 stage.
REQ-007 SHALL have port pkt_active, output, 1, high from the cycle after SYNC completes until EOP or error.
REQ-008 SHALL have port pkt_done, output, 1, one-cycle pulse on a clean EOP.
REQ-009 SHALL have port stuff_err, output, 1, one-cycle pulse on a bit-stuff violation.
REQ-010 SHALL have port eop_err, output, 1, one-cycle pulse on a malformed EOP or SE1.

Function
REQ-011 SHALL sample and act only in cycles where in_valid=1; when in_valid=0, all state holds and out_valid, pkt_done, stuff_err and eop_err are 0.
REQ-012 SHALL NRZI-decode J/K symbols as follows: same symbol as previous J/K symbol = 1; transition = 0. The previous symbol resets to J and updates only on J/K symbols.
REQ-013 SHALL register all outputs, with exactly 1 cycle latency from the accepting in_valid cycle.
REQ-014 SHALL implement the FSM states IDLE, SYNC, DATA, EOP and ERROR.
REQ-015 IDLE: first K SHALL enter SYNC with sync_cnt=1; J, SE0 and SE1 SHALL stay in IDLE.
REQ-016 SYNC: decoded bits SHALL be compared against pattern 0000000 followed by 1 (eight total, time order). A full match SHALL enter DATA with ones_cnt=1 and raise pkt_active. Any mismatch or SE0 SHALL return to IDLE silently. SE1 SHALL enter ERROR.
REQ-017 DATA, decoded 1 with ones_cnt<6: SHALL emit out_bit=1, out_valid=1, and increment ones_cnt.
REQ-018 DATA, decoded 0 with ones_cnt<6: SHALL emit out_bit=0, out_valid=1, and clear ones_cnt.
REQ-019 DATA, ones_cnt==6, decoded 0: SHALL discard the bit (out_valid=0) and clear ones_cnt.
REQ-020 DATA, ones_cnt==6, decoded 1: SHALL pulse stuff_err, drop pkt_active, and enter ERROR.
REQ-021 DATA, SE0 (any ones_cnt, including 6): SHALL enter EOP with se0_cnt=1 and emit no bit.
REQ-022 DATA, SE1: SHALL pulse eop_err and enter ERROR.
REQ-023 EOP: a second SE0 SHALL set se0_cnt=2. A J after se0_cnt>=1 SHALL pulse pkt_done, drop pkt_active, reset the previous symbol to J, and enter IDLE. K, SE1, or a third SE0 SHALL pulse eop_err and enter ERROR.
REQ-024 ERROR: SHALL return to IDLE after 7 consecutive J symbols (idle_cnt) or after an SE0 followed by J. No outputs SHALL be produced in ERROR.
REQ-025 pkt_done, stuff_err and eop_err SHALL be mutually exclusive in any cycle.
REQ-026 Counters SHALL be sized as follows: ones_cnt 3 bits, saturating at 6; sync_cnt 3 bits; idle_cnt 3 bits; se0_cnt 2 bits. No counter SHALL wrap.

Reset
REQ-027 Reset SHALL set the state to IDLE, the previous symbol to J, and all counters to 0.
REQ-028 Reset SHALL set out_bit, out_valid, pkt_active, pkt_done, stuff_err and eop_err to 0.
REQ-029 Reset asserted mid-packet SHALL abort immediately with no pkt_done or error pulse. The next packet SHALL require a full SYNC.

Structure
REQ-030 Shared package usb_rx_pkg SHALL hold line_state_t {J,K,SE0,SE1}, the rx FSM state enum, SYNC_PATTERN=8'b1000_0000 (LSB first in time), and MAX_ONES=6.
REQ-031 Sub-module nrzi_line_decode SHALL map dp/dm to line_state_t and produce the NRZI-decoded bit plus the previous-symbol register; the FSM and counters SHALL reside in rx_nrzi_unstuff.

Verification
REQ-032 Clean packet: SYNC KJKJKJKK, data 8'hC3 LSB first, SE0 SE0 J -> 8 out_valid pulses with bits 1,1,0,0,0,0,1,1; pkt_active high throughout; one pkt_done; no errors.
REQ-033 Stuffing: SYNC, then data 1111111 (seven ones) with a stuffed 0 after the fifth data one (counting the SYNC 1 as the first one), then EOP -> 7 out_valid ones, stuffed bit absent, pkt_done.
REQ-034 Stuff violation: SYNC, then six 1s and a seventh 1 at ones_cnt==6 -> stuff_err pulse; pkt_active falls; ERROR is held until 7 J symbols; the next clean packet is decoded correctly.
REQ-035 Bad EOP: data followed by SE0 then K -> eop_err pulse, no pkt_done.
REQ-036 Gapped in_valid: clean packet with in_valid=0 on alternating cycles -> identical bit sequence to the clean-packet scenario; out_valid never high in a cycle following an in_valid=0 cycle.
REQ-037 Reset mid-packet: reset_n pulsed low after 3 data bits -> all outputs 0, no pulses; a following clean packet is decoded correctly.
